systolic_array_os: RTL and testbench

- Parametrised output-stationary systolic matrix-multiply engine; successor to the fixed 4x4 8-bit array.
- Computes C[ROWS][COLS] = A[ROWS][K] x B[K][COLS] for a runtime K, accumulating in place in each PE.
- Adds internal input skewing, a run/flush/drain controller, valid/ready handshakes on both sides and row-serial result drain.
- Sits between the activation/weight buffers and the partial-sum writeback unit.

---
 rtl/systolic_array_os.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_systolic_array_os.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_os.sv
`default_nettype none
// ============================================================================
// Module   : systolic_array_os
// Purpose  : Output-stationary systolic matrix-multiply engine computing
//            C[ROWS][COLS] = A[ROWS][K] x B[K][COLS] for a runtime K.
//            Operands are skewed internally, streamed through a grid of
//            multiply-accumulate PEs, flushed, then drained one result row
//            per accepted handshake.
// Ports    : clk, rst (async, active low)
//            start, k_len       - job launch and reduction depth
//            busy               - job in progress
//            in_valid/in_ready  - operand beat handshake (west_in, north_in)
//            out_valid/out_ready- result row handshake (out_row, out_data)
// Options  : SA_SAT_EN - when defined, accumulators saturate to the signed
//            ACC_DW range instead of wrapping.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module systolic_array_os #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int WEST_DW  = 8,
    parameter int NORTH_DW = 8,
    parameter int ACC_DW   = 24,
    parameter int K_W      = 10
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic [K_W-1:0]                              k_len,
    output logic                                        busy,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [ROWS*WEST_DW-1:0]                     west_in,
    input  logic [COLS*NORTH_DW-1:0]                    north_in,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0]  out_row,
    output logic [COLS*ACC_DW-1:0]                      out_data
);

    localparam int c_RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int c_PW = WEST_DW + NORTH_DW;
    localparam int c_FW = $clog2(ROWS + COLS) + 1;
    // Extra advances needed for the last operand pair to reach the far PE
    localparam logic [c_FW-1:0] c_FLUSH_LEN = c_FW'(ROWS + COLS - 2);
    localparam logic [c_RW-1:0] c_LAST_ROW  = c_RW'(ROWS - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_LOAD  = 2'd1;
    localparam logic [1:0] c_S_FLUSH = 2'd2;
    localparam logic [1:0] c_S_DRAIN = 2'd3;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [K_W-1:0]         r_k_len;
    logic [K_W-1:0]         r_k_cnt;
    logic [c_FW-1:0]        r_flush_cnt;
    logic [c_RW-1:0]        r_out_row;
    logic [COLS*ACC_DW-1:0] r_out_data;

    logic                   w_accept_start;
    logic                   w_clr;
    logic                   w_xfer;
    logic                   w_last_beat;
    logic                   w_flush_done;
    logic                   w_adv;
    logic                   w_row_accept;
    logic                   w_last_row;
    logic [c_RW-1:0]        w_sel_row;
    logic [COLS*ACC_DW-1:0] w_sel_data;

    logic signed [WEST_DW-1:0]  w_west_sk [ROWS];
    logic signed [NORTH_DW-1:0] w_north_sk [COLS];
    logic signed [WEST_DW-1:0]  w_a_out [ROWS][COLS];
    logic signed [NORTH_DW-1:0] w_b_out [ROWS][COLS];
    logic signed [ACC_DW-1:0]   w_acc [ROWS][COLS];

    assign w_accept_start = (r_state == c_S_IDLE) && start;
    assign w_clr          = w_accept_start;
    assign w_xfer         = (r_state == c_S_LOAD) && in_valid;
    assign w_last_beat    = w_xfer && (r_k_cnt == (r_k_len - K_W'(1)));
    assign w_flush_done   = (r_state == c_S_FLUSH) && (r_flush_cnt == c_FLUSH_LEN);
    // Single global enable: the whole array (skew chains and PEs) steps together
    assign w_adv          = w_xfer || ((r_state == c_S_FLUSH) && !w_flush_done);
    assign w_row_accept   = (r_state == c_S_DRAIN) && out_ready;
    assign w_last_row     = (r_out_row == c_LAST_ROW);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (start) begin
                    w_state_nxt = (k_len == '0) ? c_S_DRAIN : c_S_LOAD;
                end
            end
            c_S_LOAD: begin
                if (w_last_beat) w_state_nxt = c_S_FLUSH;
            end
            c_S_FLUSH: begin
                if (w_flush_done) w_state_nxt = c_S_DRAIN;
            end
            c_S_DRAIN: begin
                if (w_row_accept && w_last_row) w_state_nxt = c_S_IDLE;
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Counters and result row register
    // ------------------------------------------------------------------
    // Row to load next: row 0 when leaving FLUSH, otherwise the following row.
    assign w_sel_row = (w_flush_done || w_last_row) ? '0 : (r_out_row + c_RW'(1));

    always_comb begin
        w_sel_data = '0;
        for (int c = 0; c < COLS; c++) begin
            w_sel_data[c*ACC_DW +: ACC_DW] = w_acc[w_sel_row][c];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_k_len     <= '0;
            r_k_cnt     <= '0;
            r_flush_cnt <= '0;
            r_out_row   <= '0;
            r_out_data  <= '0;
        end else begin
            if (w_accept_start) begin
                r_k_len     <= k_len;
                r_k_cnt     <= '0;
                r_flush_cnt <= '0;
                r_out_row   <= '0;
                // Zero here so a K=0 job drains cleared rows straight away
                r_out_data  <= '0;
            end
            if (w_xfer) begin
                r_k_cnt <= r_k_cnt + K_W'(1);
            end
            if ((r_state == c_S_FLUSH) && !w_flush_done) begin
                r_flush_cnt <= r_flush_cnt + c_FW'(1);
            end
            if (w_flush_done) begin
                r_out_row  <= '0;
                r_out_data <= w_sel_data;
            end
            if (w_row_accept) begin
                if (w_last_row) begin
                    r_out_row <= '0;
                end else begin
                    r_out_row  <= r_out_row + c_RW'(1);
                    r_out_data <= w_sel_data;
                end
            end
        end
    end

    assign busy      = (r_state != c_S_IDLE);
    assign in_ready  = (r_state == c_S_LOAD);
    assign out_valid = (r_state == c_S_DRAIN);
    assign out_row   = r_out_row;
    assign out_data  = r_out_data;

    // ------------------------------------------------------------------
    // Input skew: west lane r delayed r steps, north lane c delayed c steps.
    // Zeros are injected outside LOAD so FLUSH drains the pipeline cleanly.
    // ------------------------------------------------------------------
    for (genvar r = 0; r < ROWS; r++) begin : g_west_skew
        logic signed [WEST_DW-1:0] w_lane;
        assign w_lane = (r_state == c_S_LOAD) ? west_in[r*WEST_DW +: WEST_DW] : '0;
        if (r == 0) begin : g_direct
            assign w_west_sk[r] = w_lane;
        end else begin : g_delay
            logic signed [WEST_DW-1:0] r_sr [r];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < r; i++) r_sr[i] <= '0;
                end else if (w_clr) begin
                    for (int i = 0; i < r; i++) r_sr[i] <= '0;
                end else if (w_adv) begin
                    r_sr[0] <= w_lane;
                    for (int i = 1; i < r; i++) r_sr[i] <= r_sr[i-1];
                end
            end
            assign w_west_sk[r] = r_sr[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_north_skew
        logic signed [NORTH_DW-1:0] w_lane;
        assign w_lane = (r_state == c_S_LOAD) ? north_in[c*NORTH_DW +: NORTH_DW] : '0;
        if (c == 0) begin : g_direct
            assign w_north_sk[c] = w_lane;
        end else begin : g_delay
            logic signed [NORTH_DW-1:0] r_sr [c];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < c; i++) r_sr[i] <= '0;
                end else if (w_clr) begin
                    for (int i = 0; i < c; i++) r_sr[i] <= '0;
                end else if (w_adv) begin
                    r_sr[0] <= w_lane;
                    for (int i = 1; i < c; i++) r_sr[i] <= r_sr[i-1];
                end
            end
            assign w_north_sk[c] = r_sr[c-1];
        end
    end

    // ------------------------------------------------------------------
    // PE grid: a flows east, b flows south, acc stays put.
    // ------------------------------------------------------------------
    for (genvar r = 0; r < ROWS; r++) begin : g_pe_row
        for (genvar c = 0; c < COLS; c++) begin : g_pe_col
            logic signed [WEST_DW-1:0]  w_a_in;
            logic signed [WEST_DW-1:0]  r_a;
            logic signed [NORTH_DW-1:0] w_b_in;
            logic signed [NORTH_DW-1:0] r_b;
            logic signed [c_PW-1:0]     w_prod;
            logic signed [ACC_DW-1:0]   w_prod_ext;
            logic signed [ACC_DW-1:0]   w_acc_nxt;
            logic signed [ACC_DW-1:0]   r_acc;

            if (c == 0) begin : g_a_edge
                assign w_a_in = w_west_sk[r];
            end else begin : g_a_pass
                assign w_a_in = w_a_out[r][c-1];
            end

            if (r == 0) begin : g_b_edge
                assign w_b_in = w_north_sk[c];
            end else begin : g_b_pass
                assign w_b_in = w_b_out[r-1][c];
            end

            assign w_prod     = c_PW'(w_a_in) * c_PW'(w_b_in);
            assign w_prod_ext = ACC_DW'(w_prod);

`ifdef SA_SAT_EN
            // One guard bit exposes overflow of the single addition; the
            // product always fits in ACC_DW so one guard bit is enough.
            logic signed [ACC_DW:0] w_sum;
            assign w_sum = {r_acc[ACC_DW-1], r_acc} + {w_prod_ext[ACC_DW-1], w_prod_ext};
            always_comb begin
                if (w_sum[ACC_DW] != w_sum[ACC_DW-1]) begin
                    w_acc_nxt = w_sum[ACC_DW] ? {1'b1, {(ACC_DW-1){1'b0}}}
                                              : {1'b0, {(ACC_DW-1){1'b1}}};
                end else begin
                    w_acc_nxt = w_sum[ACC_DW-1:0];
                end
            end
`else
            assign w_acc_nxt = r_acc + w_prod_ext;
`endif

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_acc <= '0;
                end else if (w_clr) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_acc <= '0;
                end else if (w_adv) begin
                    r_a   <= w_a_in;
                    r_b   <= w_b_in;
                    r_acc <= w_acc_nxt;
                end
            end

            assign w_a_out[r][c] = r_a;
            assign w_b_out[r][c] = r_b;
            assign w_acc[r][c]   = r_acc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_os.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_array_os
// Purpose  : Directed self-checking bench for systolic_array_os. A default
//            4x4 instance covers identity, signed, stall, K=0, ignored start,
//            back-to-back and mid-job reset jobs; a 16-bit accumulator
//            instance covers accumulator overflow (wrap or SA_SAT_EN clamp).
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_array_os;

    localparam int c_KW = 10;
`ifdef SA_SAT_EN
    localparam int c_OV_EXP = 32767;
`else
    localparam int c_OV_EXP = -17149;
`endif

    logic            r_clk       = 1'b0;
    logic            r_rst       = 1'b0;
    logic            r_start     = 1'b0;
    logic            r_start_ov  = 1'b0;
    logic [c_KW-1:0] r_k_len     = '0;
    logic            r_in_valid  = 1'b0;
    logic [31:0]     r_west_in   = '0;
    logic [31:0]     r_north_in  = '0;
    logic            r_out_ready = 1'b1;

    logic        w_busy, w_in_ready, w_out_valid;
    logic [1:0]  w_out_row;
    logic [95:0] w_out_data;
    logic        w_busy_ov, w_in_ready_ov, w_out_valid_ov;
    logic [1:0]  w_out_row_ov;
    logic [63:0] w_out_data_ov;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int start_cyc = 0;
    bit sel_ov    = 1'b0;

    int mat_a [4][16];
    int mat_b [16][4];
    int exp_c [4][4];
    logic signed [63:0] got_c [4][4];

    systolic_array_os dut (
        .clk       (r_clk),
        .rst       (r_rst),
        .start     (r_start),
        .k_len     (r_k_len),
        .busy      (w_busy),
        .in_valid  (r_in_valid),
        .in_ready  (w_in_ready),
        .west_in   (r_west_in),
        .north_in  (r_north_in),
        .out_valid (w_out_valid),
        .out_ready (r_out_ready),
        .out_row   (w_out_row),
        .out_data  (w_out_data)
    );

    systolic_array_os #(.ACC_DW(16)) dut_ov (
        .clk       (r_clk),
        .rst       (r_rst),
        .start     (r_start_ov),
        .k_len     (r_k_len),
        .busy      (w_busy_ov),
        .in_valid  (r_in_valid),
        .in_ready  (w_in_ready_ov),
        .west_in   (r_west_in),
        .north_in  (r_north_in),
        .out_valid (w_out_valid_ov),
        .out_ready (r_out_ready),
        .out_row   (w_out_row_ov),
        .out_data  (w_out_data_ov)
    );

    always #5 r_clk = ~r_clk;
    always @(posedge r_clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic get_valid();
        return sel_ov ? w_out_valid_ov : w_out_valid;
    endfunction

    function automatic logic get_busy();
        return sel_ov ? w_busy_ov : w_busy;
    endfunction

    function automatic logic get_in_ready();
        return sel_ov ? w_in_ready_ov : w_in_ready;
    endfunction

    function automatic logic [1:0] get_row();
        return sel_ov ? w_out_row_ov : w_out_row;
    endfunction

    function automatic logic signed [63:0] get_col(input int c);
        if (sel_ov) return 64'($signed(w_out_data_ov[c*16 +: 16]));
        return 64'($signed(w_out_data[c*24 +: 24]));
    endfunction

    // Reference product of the first k columns of A and rows of B
    task automatic model(input int k);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                longint s = 0;
                for (int kk = 0; kk < k; kk++) s += longint'(mat_a[r][kk]) * mat_b[kk][c];
                exp_c[r][c] = int'(s);
            end
        end
    endtask

    task automatic do_start(input int k);
        r_k_len = c_KW'(k);
        if (sel_ov) r_start_ov = 1'b1;
        else        r_start    = 1'b1;
        @(negedge r_clk);
        r_start    = 1'b0;
        r_start_ov = 1'b0;
        start_cyc  = cyc;
        check("busy_after_start", get_busy(), 1);
    endtask

    // Beats on consecutive cycles, with 'gap' idle cycles between beats;
    // at beat index 'poke' a start with k_len=0 is pulsed while busy.
    task automatic feed(input int k, input int gap, input int poke);
        for (int kk = 0; kk < k; kk++) begin
            for (int r = 0; r < 4; r++) r_west_in[r*8 +: 8]  = 8'(mat_a[r][kk]);
            for (int c = 0; c < 4; c++) r_north_in[c*8 +: 8] = 8'(mat_b[kk][c]);
            r_in_valid = 1'b1;
            if (kk == poke) begin
                r_start = 1'b1;
                r_k_len = '0;
            end
            check($sformatf("in_ready beat%0d", kk), get_in_ready(), 1);
            @(negedge r_clk);
            r_start = 1'b0;
            if (gap > 0 && kk < k - 1) begin
                r_in_valid = 1'b0;
                r_west_in  = 32'hA5A5_A5A5;
                r_north_in = 32'h5A5A_5A5A;
                repeat (gap) @(negedge r_clk);
            end
        end
        // Leave garbage valid beats up outside LOAD; they must be ignored
        r_west_in  = 32'h7F80_7F80;
        r_north_in = 32'h807F_807F;
    endtask

    task automatic drain(input int stall_row, input int stall_cyc,
                         input bit chk_lat, input int lat);
        for (int r = 0; r < 4; r++) begin
            int n = 0;
            while (get_valid() !== 1'b1 && n < 200) begin
                @(negedge r_clk);
                n++;
            end
            check($sformatf("out_valid row%0d", r), get_valid(), 1);
            if (r == 0 && chk_lat) check("latency", cyc - start_cyc, lat);
            check($sformatf("out_row row%0d", r), get_row(), r);
            for (int c = 0; c < 4; c++) begin
                got_c[r][c] = get_col(c);
                check($sformatf("data r%0d c%0d", r, c), got_c[r][c], exp_c[r][c]);
            end
            if (r == stall_row) begin
                r_out_ready = 1'b0;
                repeat (stall_cyc) begin
                    @(negedge r_clk);
                    check("stall_valid", get_valid(), 1);
                    check("stall_row", get_row(), r);
                    for (int c = 0; c < 4; c++)
                        check($sformatf("stall_data c%0d", c), get_col(c), exp_c[r][c]);
                end
                r_out_ready = 1'b1;
            end
            @(negedge r_clk);
        end
        check("done_valid", get_valid(), 0);
        check("done_busy", get_busy(), 0);
        check("done_row", get_row(), 0);
    endtask

    initial begin
        repeat (3) @(negedge r_clk);
        check("rst_busy", w_busy, 0);
        check("rst_in_ready", w_in_ready, 0);
        check("rst_out_valid", w_out_valid, 0);
        check("rst_out_row", w_out_row, 0);
        check("rst_data_lo", w_out_data[63:0], 0);
        check("rst_data_hi", w_out_data[95:64], 0);
        r_rst = 1'b1;
        @(negedge r_clk);

        // Identity: A = I4, B[k][c] = 4k+c, so C = B
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) mat_a[r][k] = (r == k) ? 1 : 0;
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 4; c++) mat_b[k][c] = k * 4 + c;
        model(4);
        do_start(4);
        feed(4, 0, -1);
        drain(-1, 0, 1'b1, 11);

        // Signed extremes, K=1
        mat_a[0][0] = -1;   mat_a[1][0] = 2;  mat_a[2][0] = -128; mat_a[3][0] = 127;
        mat_b[0][0] = -128; mat_b[0][1] = 1;  mat_b[0][2] = -1;   mat_b[0][3] = 127;
        model(1);
        do_start(1);
        feed(1, 0, -1);
        drain(-1, 0, 1'b1, 8);
        check("signed_c20", got_c[2][0], 16384);
        check("signed_c33", got_c[3][3], 16129);
        check("signed_c01", got_c[0][1], -1);

        // K=3 unstalled, then the same job with input gaps and an output stall
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 3; k++) mat_a[r][k] = r * 3 - k * 5 + 1;
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < 4; c++) mat_b[k][c] = (c - 2) * (k + 1) + 7;
        model(3);
        do_start(3);
        feed(3, 0, -1);
        drain(-1, 0, 1'b1, 10);
        do_start(3);
        feed(3, 2, -1);
        drain(1, 3, 1'b0, 0);

        // K=0: four zero rows
        model(0);
        do_start(0);
        drain(-1, 0, 1'b0, 0);

        // K=2 with a start pulse during LOAD that must be ignored
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 2; k++) mat_a[r][k] = (k == 0) ? (r + 1) : -(r + 2);
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 4; c++) mat_b[k][c] = (k == 0) ? (c * 10 - 7) : (3 - c);
        model(2);
        do_start(2);
        feed(2, 0, 1);
        drain(-1, 0, 1'b1, 9);

        // Back-to-back K=1 job: no leftover accumulation
        for (int r = 0; r < 4; r++) mat_a[r][0] = r - 2;
        for (int c = 0; c < 4; c++) mat_b[0][c] = 5 - c;
        model(1);
        do_start(1);
        feed(1, 0, -1);
        drain(-1, 0, 1'b1, 8);

        // Reset during LOAD after two beats
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) mat_a[r][k] = 9;
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 4; c++) mat_b[k][c] = 9;
        do_start(4);
        feed(2, 0, -1);
        #1 r_rst = 1'b0;
        #1;
        check("midrst_busy", w_busy, 0);
        check("midrst_in_ready", w_in_ready, 0);
        check("midrst_out_valid", w_out_valid, 0);
        r_in_valid = 1'b0;
        @(negedge r_clk);
        r_rst = 1'b1;
        repeat (3) @(negedge r_clk);
        check("postrst_out_valid", w_out_valid, 0);
        check("postrst_busy", w_busy, 0);
        for (int r = 0; r < 4; r++) mat_a[r][0] = 1;
        for (int c = 0; c < 4; c++) mat_b[0][c] = 1;
        model(1);
        do_start(1);
        feed(1, 0, -1);
        drain(-1, 0, 1'b1, 8);

        // Overflow on the 16-bit accumulator instance: 3 x 127*127 = 48387
        sel_ov = 1'b1;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 3; k++) mat_a[r][k] = 127;
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < 4; c++) mat_b[k][c] = 127;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) exp_c[r][c] = c_OV_EXP;
        do_start(3);
        feed(3, 0, -1);
        drain(-1, 0, 1'b1, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
